// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl_pkg
//  Description : Shared constants, MDU state encodings and the RAW hazard
//                helper used by the pipeline hazard controller.
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_hazard_ctrl_pkg;

    // A Tuse of 3 marks an operand the instruction does not read.
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // CP0 register index of EPC.
    localparam logic [4:0] CP0_EPC   = 5'd14;

    // MDU occupancy state encodings.
    localparam logic [1:0] MDU_IDLE  = 2'd0;
    localparam logic [1:0] MDU_MULT  = 2'd1;
    localparam logic [1:0] MDU_DIV   = 2'd2;

    // Default MDU latencies in busy cycles.
    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    // True when a D-stage source read at tuse would see a value that the
    // producer (dest a3, write-enable we, tnew) has not yet computed.
    function automatic logic raw_hit(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] a3,
        input logic [1:0] tnew,
        input logic       we
    );
        raw_hit = (src != 5'd0) && (tuse != TUSE_NONE) && we &&
                  (a3 == src) && (tuse < tnew);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_mdu_busy_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_busy_tracker
//  Description : Tracks multi-cycle MDU occupancy. An accepted start loads
//                the latency counter; busy holds for exactly that many cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module mdu_busy_tracker
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             div,
    input  logic             req,
    output logic             busy,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] C_MULT_LAT = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] C_DIV_LAT  = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // State and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= MDU_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: starts are only taken from IDLE (a start while busy is
    // dropped, never reloaded); an in-flight op always runs to completion.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            MDU_IDLE: begin
                w_cnt_nxt = '0;
                if (start && !req) begin
                    w_state_nxt = div ? MDU_DIV : MDU_MULT;
                    w_cnt_nxt   = div ? C_DIV_LAT : C_MULT_LAT;
                end
            end
            MDU_MULT, MDU_DIV: begin
                if (r_cnt <= C_ONE) begin
                    w_state_nxt = MDU_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - C_ONE;
                end
            end
            default: begin
                w_state_nxt = MDU_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign busy = (r_state != MDU_IDLE);
    assign cnt  = r_cnt;

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Hazard and MDU scheduler for the 5-stage pipeline. Produces
//                the stall that holds F/D and bubbles D->E, covering register
//                RAW hazards, MDU structural hazards and eret-after-mtc0(EPC).
//                Optional macro STALL_PERF_EN adds a 32-bit stall counter.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       d_a1,
    input  logic [4:0]       d_a2,
    input  logic [1:0]       d_tuse_rs,
    input  logic [1:0]       d_tuse_rt,
    input  logic             d_mdu_use,
    input  logic             d_eret,
    input  logic [4:0]       e_a3,
    input  logic [1:0]       e_tnew,
    input  logic             e_rf_we,
    input  logic             e_mdu_start,
    input  logic             e_mdu_div,
    input  logic             e_mtc0_epc,
    input  logic [4:0]       m_a3,
    input  logic [1:0]       m_tnew,
    input  logic             m_rf_we,
    input  logic             m_mtc0_epc,
    input  logic             req,
    output logic             stall,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] mdu_cnt
`ifdef STALL_PERF_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);

    logic w_rs_raw;
    logic w_rt_raw;
    logic w_mdu_haz;
    logic w_eret_haz;

    mdu_busy_tracker #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (CNT_W)
    ) u_mdu_busy_tracker (
        .clk   (clk),
        .reset (reset),
        .start (e_mdu_start),
        .div   (e_mdu_div),
        .req   (req),
        .busy  (mdu_busy),
        .cnt   (mdu_cnt)
    );

    // Hazard terms and the combined stall; a flush request or reset wins.
    always_comb begin
        w_rs_raw   = raw_hit(d_a1, d_tuse_rs, e_a3, e_tnew, e_rf_we) ||
                     raw_hit(d_a1, d_tuse_rs, m_a3, m_tnew, m_rf_we);
        w_rt_raw   = raw_hit(d_a2, d_tuse_rt, e_a3, e_tnew, e_rf_we) ||
                     raw_hit(d_a2, d_tuse_rt, m_a3, m_tnew, m_rf_we);
        w_mdu_haz  = d_mdu_use && (mdu_busy || e_mdu_start);
        w_eret_haz = d_eret && (e_mtc0_epc || m_mtc0_epc);
        stall      = reset && !req &&
                     (w_rs_raw || w_rt_raw || w_mdu_haz || w_eret_haz);
    end

`ifdef STALL_PERF_EN
    logic [31:0] r_stall_cnt;

    // Counts stalled cycles; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (stall && !req) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Directed self-checking bench for pipe_hazard_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] d_a1, d_a2, e_a3, m_a3;
    logic [1:0] d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
    logic       d_mdu_use, d_eret, e_rf_we, e_mdu_start, e_mdu_div;
    logic       e_mtc0_epc, m_rf_we, m_mtc0_epc, req;
    logic       stall, mdu_busy;
    logic [3:0] mdu_cnt;
`ifdef STALL_PERF_EN
    logic [31:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    pipe_hazard_ctrl #(
        .MULT_LAT (5),
        .DIV_LAT  (10),
        .CNT_W    (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .d_a1        (d_a1),
        .d_a2        (d_a2),
        .d_tuse_rs   (d_tuse_rs),
        .d_tuse_rt   (d_tuse_rt),
        .d_mdu_use   (d_mdu_use),
        .d_eret      (d_eret),
        .e_a3        (e_a3),
        .e_tnew      (e_tnew),
        .e_rf_we     (e_rf_we),
        .e_mdu_start (e_mdu_start),
        .e_mdu_div   (e_mdu_div),
        .e_mtc0_epc  (e_mtc0_epc),
        .m_a3        (m_a3),
        .m_tnew      (m_tnew),
        .m_rf_we     (m_rf_we),
        .m_mtc0_epc  (m_mtc0_epc),
        .req         (req),
        .stall       (stall),
        .mdu_busy    (mdu_busy),
        .mdu_cnt     (mdu_cnt)
`ifdef STALL_PERF_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs and checks sit mid-cycle.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        d_a1 = 0; d_a2 = 0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3;
        d_mdu_use = 0; d_eret = 0;
        e_a3 = 0; e_tnew = 0; e_rf_we = 0; e_mdu_start = 0; e_mdu_div = 0;
        e_mtc0_epc = 0; m_a3 = 0; m_tnew = 0; m_rf_we = 0; m_mtc0_epc = 0;
        req = 0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;

        // Reset held with hazards and starts toggling.
        for (int i = 0; i < 3; i++) begin
            d_a1 = 5'd5; d_tuse_rs = 2'd0; e_a3 = 5'd5; e_tnew = 2'd2;
            e_rf_we = i[0]; e_mdu_start = 1'b1; e_mdu_div = i[1];
            d_mdu_use = 1'b1; d_eret = 1'b1; e_mtc0_epc = 1'b1;
            #1;
            chk("rst_stall", {31'd0, stall}, 32'd0);
            step();
        end
        chk("rst_busy", {31'd0, mdu_busy}, 32'd0);
        chk("rst_cnt", {28'd0, mdu_cnt}, 32'd0);
        clear_inputs();
        reset = 1'b1;
        step();
        chk("post_rst_busy", {31'd0, mdu_busy}, 32'd0);

        // RAW: lw in E, add in D reading rs at Tuse 1.
        d_a1 = 5'd5; d_tuse_rs = 2'd1; e_a3 = 5'd5; e_tnew = 2'd2; e_rf_we = 1;
        #1 chk("raw_e_rs", {31'd0, stall}, 32'd1);
        step();
        e_rf_we = 0; e_a3 = 0; m_a3 = 5'd5; m_tnew = 2'd1; m_rf_we = 1;
        #1 chk("raw_m_resolved", {31'd0, stall}, 32'd0);
        m_tnew = 2'd2;
        #1 chk("raw_m_rs", {31'd0, stall}, 32'd1);
        clear_inputs();
        d_a1 = 5'd0; d_tuse_rs = 2'd0; e_a3 = 5'd0; e_tnew = 2'd2; e_rf_we = 1;
        #1 chk("raw_r0", {31'd0, stall}, 32'd0);
        clear_inputs();
        d_a2 = 5'd7; d_tuse_rt = 2'd0; e_a3 = 5'd7; e_tnew = 2'd1; e_rf_we = 1;
        #1 chk("raw_e_rt", {31'd0, stall}, 32'd1);
        d_tuse_rt = 2'd3; e_tnew = 2'd3;
        #1 chk("raw_tuse_none", {31'd0, stall}, 32'd0);
        d_tuse_rt = 2'd0; e_tnew = 2'd1; e_rf_we = 0;
        #1 chk("raw_no_we", {31'd0, stall}, 32'd0);
        e_rf_we = 1; req = 1;
        #1 chk("raw_req_prio", {31'd0, stall}, 32'd0);
        clear_inputs();
        step();

        // div start with mflo waiting in D.
        d_mdu_use = 1; e_mdu_start = 1; e_mdu_div = 1;
        #1 chk("div_start_stall", {31'd0, stall}, 32'd1);
        chk("div_start_idle", {31'd0, mdu_busy}, 32'd0);
        step();
        e_mdu_start = 0; e_mdu_div = 0;
        for (int k = 0; k < 10; k++) begin
            chk("div_busy", {31'd0, mdu_busy}, 32'd1);
            chk("div_cnt", {28'd0, mdu_cnt}, 32'(10 - k));
            chk("div_stall", {31'd0, stall}, 32'd1);
            step();
        end
        chk("div_done_busy", {31'd0, mdu_busy}, 32'd0);
        chk("div_done_cnt", {28'd0, mdu_cnt}, 32'd0);
        chk("div_done_stall", {31'd0, stall}, 32'd0);
        clear_inputs();

        // Start blocked by req.
        e_mdu_start = 1; req = 1;
        step();
        chk("req_block_busy", {31'd0, mdu_busy}, 32'd0);
        clear_inputs();

        // mult in flight survives req and ignores a stray start.
        e_mdu_start = 1; e_mdu_div = 0;
        step();
        e_mdu_start = 0;
        for (int k = 0; k < 5; k++) begin
            chk("mult_busy", {31'd0, mdu_busy}, 32'd1);
            chk("mult_cnt", {28'd0, mdu_cnt}, 32'(5 - k));
            req         = (k == 1);
            e_mdu_start = (k == 2);
            e_mdu_div   = (k == 2);
            step();
            req = 0; e_mdu_start = 0; e_mdu_div = 0;
        end
        chk("mult_done_busy", {31'd0, mdu_busy}, 32'd0);
        chk("mult_done_cnt", {28'd0, mdu_cnt}, 32'd0);

        // eret behind mtc0 EPC in E then in M.
        d_eret = 1; e_mtc0_epc = 1;
        #1 chk("eret_e", {31'd0, stall}, 32'd1);
        step();
        e_mtc0_epc = 0; m_mtc0_epc = 1;
        #1 chk("eret_m", {31'd0, stall}, 32'd1);
        step();
        m_mtc0_epc = 0;
        #1 chk("eret_clear", {31'd0, stall}, 32'd0);
        clear_inputs();

`ifdef STALL_PERF_EN
        // Fresh reset, then 3 RAW stall edges, one suppressed by req,
        // and 11 MDU stall edges.
        step();
        reset = 0;
        #1 chk("perf_rst", stall_cnt, 32'd0);
        reset = 1;
        step();
        d_a1 = 5'd3; d_tuse_rs = 2'd0; e_a3 = 5'd3; e_tnew = 2'd1; e_rf_we = 1;
        step(); step(); step();
        req = 1;
        step();
        clear_inputs();
        chk("perf_raw", stall_cnt, 32'd3);
        d_mdu_use = 1; e_mdu_start = 1; e_mdu_div = 1;
        step();
        e_mdu_start = 0; e_mdu_div = 0;
        for (int k = 0; k < 10; k++) step();
        clear_inputs();
        step();
        chk("perf_total", stall_cnt, 32'd14);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Hazard and multiply/divide scheduler for the 5-stage pipeline. Produces the single `stall` that holds F/D and bubbles the D→E register, and tracks the multi-cycle MDU occupancy started from the E stage. Handles RAW hazards on the register file, MDU structural hazards, and eret-after-mtc0(EPC) ordering. Sits beside the pipeline registers and consumes their Tnew/A3/rf_we/mdu_start outputs.

Parameters:
MULT_LAT, 5, busy cycles after an accepted mult/multu start
DIV_LAT, 10, busy cycles after an accepted div/divu start
CNT_W, 4, width of the MDU busy counter; must hold max(MULT_LAT, DIV_LAT)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
d_a1  in  5  D-stage rs index
d_a2  in  5  D-stage rt index
d_tuse_rs  in  2  D-stage rs Tuse (3 = not used)
d_tuse_rt  in  2  D-stage rt Tuse (3 = not used)
d_mdu_use  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
d_eret  in  1  D-stage instruction is eret
e_a3  in  5  E-stage destination register
e_tnew  in  2  E-stage Tnew
e_rf_we  in  1  E-stage register write enable
e_mdu_start  in  1  E-stage mdu_start
e_mdu_div  in  1  E-stage MDU op is div/divu (0 = mult/multu)
e_mtc0_epc  in  1  E-stage is mtc0 to CP0 reg 14
m_a3  in  5  M-stage destination register
m_tnew  in  2  M-stage Tnew
m_rf_we  in  1  M-stage register write enable
m_mtc0_epc  in  1  M-stage is mtc0 to CP0 reg 14
req  in  1  exception/interrupt flush request from CP0
stall  out  1  hold F and D registers, bubble E register
mdu_busy  out  1  MDU operation in flight
mdu_cnt  out  CNT_W  remaining busy cycles

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, mdu_cnt=0, mdu_busy=0; stall forced 0 while reset=0.
- FSM states IDLE, MULT, DIV; mdu_busy=1 exactly when state != IDLE.
- Start accepted when e_mdu_start=1 and req=0. Accepted in IDLE: next state MULT/DIV by e_mdu_div, mdu_cnt loads MULT_LAT or DIV_LAT. The cycle of e_mdu_start is not counted as busy; mdu_busy rises on the next edge.
- MULT/DIV: mdu_cnt decrements each cycle; on the edge where mdu_cnt==1, next state IDLE with mdu_cnt 0. Busy therefore lasts exactly LAT cycles.
- A start while busy is impossible, because stall blocks it; if it occurs anyway, ignore it and do not reload.
- req=1 blocks a same-cycle start. An operation already in flight continues to completion; HI/LO state survives the exception.
- stall is combinational, OR of:
  - rs RAW: d_a1!=0 and ((e_rf_we and e_a3==d_a1 and d_tuse_rs<e_tnew) or (m_rf_we and m_a3==d_a1 and d_tuse_rs<m_tnew))
  - rt RAW: same with d_a2 and d_tuse_rt
  - MDU: d_mdu_use and (mdu_busy or e_mdu_start)
  - eret: d_eret and (e_mtc0_epc or m_mtc0_epc)
- Tuse=3 never stalls. Register 0 never stalls. Comparisons are 2-bit unsigned.
- req has priority: when req=1, stall=0, because the pipeline registers flush.

Optional Feature:
STALL_PERF_EN
- Defined: adds output `stall_cnt` [31:0]. It increments on every edge where stall=1, reset=1 and req=0, wraps at 2^32-1→0, and clears on reset.
- Not defined: no counter and no port.

Decomposition:
- Shared package/header holds TUSE_NONE=2'd3, CP0_EPC=5'd14, the FSM state encodings MDU_IDLE/MDU_MULT/MDU_DIV, and the MULT/DIV latency defaults.
- Sub-module `mdu_busy_tracker` holds the FSM and counter, with ports clk, reset, start, div, req, busy, cnt. Stall logic remains combinational in the top.

Test Plan:
- Reset held low with all inputs toggling -> stall=0, mdu_busy=0, mdu_cnt=0. Release -> state IDLE.
- lw in E (e_a3=5, e_tnew=2, e_rf_we=1) with D add using rs=5 and d_tuse_rs=1 -> stall=1. Next cycle with m_tnew=1 -> stall=0. Same scenario with d_a1=0 -> stall=0.
- e_mdu_start=1, e_mdu_div=1 -> mdu_busy=1 for exactly 10 cycles, mdu_cnt 10→1. A D-stage mflo stalls for those 10 cycles plus the start cycle, then releases.
- e_mdu_start=1 together with req=1 -> no start, mdu_busy stays 0. A mult in flight when req fires -> still completes after 5 busy cycles.
- d_eret with e_mtc0_epc=1 -> stall=1. Next cycle with m_mtc0_epc=1 -> stall=1. Following cycle -> stall=0.
- With STALL_PERF_EN: 3 RAW stalls and 11 MDU stall cycles -> stall_cnt=14. Preload near 2^32-1 -> wraps to 0.
